draw_sequencer: RTL and testbench

Frame-level draw controller that sits directly upstream of the map/HUD drawer and the sprite drawer. It generates the 60 Hz frame tick and issues one-at-a-time draw requests (`draw_map`, `draw_HUD`, `erase_link`, `draw_link`) with level/done handshakes. It also pulses `update_pos` so game logic moves the player between erase and redraw. It records frames lost to overrun.

---
 rtl/draw_sequencer.sv | 144 ++++++++++++++
 tb/tb_draw_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Frame-level draw controller: generates the frame tick, sequences one-at-a-time
// draw requests to the map/HUD and sprite drawers, and counts overrun frames.
module draw_sequencer #(
    parameter int unsigned FRAME_TICKS = 833333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       map_change,
    input  logic       hud_dirty,
    input  logic       draw_map_done,
    input  logic       draw_HUD_done,
    input  logic       draw_link_done,
    output logic       draw_map,
    output logic       draw_HUD,
    output logic       erase_link,
    output logic       draw_link,
    output logic       update_pos,
    output logic       frame_tick,
    output logic       busy,
    output logic [7:0] frames_dropped
);
    localparam int unsigned CNT_W  = $clog2(FRAME_TICKS);
    localparam int unsigned DROP_W = 8;
    localparam logic [CNT_W-1:0]  FCNT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;

    typedef enum logic [2:0] {
        S_INIT_MAP,
        S_INIT_HUD,
        S_IDLE,
        S_MAP,
        S_HUD,
        S_ERASE,
        S_UPDATE,
        S_DRAW
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic                frame_tick_q, frame_tick_d;
    logic                map_pend_q, map_pend_d;
    logic                hud_pend_q, hud_pend_d;
    logic                draw_map_q, draw_map_d;
    logic                draw_hud_q, draw_hud_d;
    logic                erase_link_q, erase_link_d;
    logic                draw_link_q, draw_link_d;
    logic                update_pos_q, update_pos_d;
    logic                busy_q, busy_d;
    logic [DROP_W-1:0]   dropped_q, dropped_d;

    logic map_ack_c;
    logic hud_ack_c;
    logic erase_ack_c;
    logic draw_ack_c;
    logic enter_map_c;
    logic enter_hud_c;

    // Done pulses only count while their own request is being held.
    assign map_ack_c   = draw_map_q   & draw_map_done;
    assign hud_ack_c   = draw_hud_q   & draw_HUD_done;
    assign erase_ack_c = erase_link_q & draw_link_done;
    assign draw_ack_c  = draw_link_q  & draw_link_done;

    always_comb begin
        state_d      = state_q;
        fcnt_d       = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + CNT_W'(1);
        frame_tick_d = (fcnt_q == FCNT_LAST);
        dropped_d    = dropped_q;

        case (state_q)
            S_INIT_MAP: if (map_ack_c)   state_d = S_INIT_HUD;
            S_INIT_HUD: if (hud_ack_c)   state_d = S_IDLE;
            S_IDLE: begin
                if (map_pend_q)        state_d = S_MAP;
                else if (frame_tick_q) state_d = S_ERASE;
            end
            S_MAP:      if (map_ack_c)   state_d = S_HUD;
            S_HUD:      if (hud_ack_c)   state_d = S_IDLE;
            S_ERASE:    if (erase_ack_c) state_d = S_UPDATE;
            S_UPDATE:                    state_d = S_DRAW;
            S_DRAW:     if (draw_ack_c)  state_d = hud_pend_q ? S_HUD : S_IDLE;
            default:                     state_d = S_INIT_MAP;
        endcase

        enter_map_c = (state_d == S_MAP) && (state_q != S_MAP);
        enter_hud_c = (state_d == S_HUD) && (state_q != S_HUD);

        // Set beats clear when both land in the same cycle.
        map_pend_d = map_change | (map_pend_q & ~enter_map_c);
        hud_pend_d = hud_dirty | enter_map_c | (hud_pend_q & ~enter_hud_c);

        // A tick outside IDLE is lost, not queued.
        if (frame_tick_q && (state_q != S_IDLE) && (dropped_q != DROP_MAX)) begin
            dropped_d = dropped_q + DROP_W'(1);
        end

        draw_map_d   = (state_d == S_INIT_MAP) || (state_d == S_MAP);
        draw_hud_d   = (state_d == S_INIT_HUD) || (state_d == S_HUD);
        erase_link_d = (state_d == S_ERASE);
        draw_link_d  = (state_d == S_DRAW);
        update_pos_d = (state_d == S_UPDATE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_INIT_MAP;
            fcnt_q       <= '0;
            frame_tick_q <= 1'b0;
            map_pend_q   <= 1'b0;
            hud_pend_q   <= 1'b0;
            draw_map_q   <= 1'b0;
            draw_hud_q   <= 1'b0;
            erase_link_q <= 1'b0;
            draw_link_q  <= 1'b0;
            update_pos_q <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            frame_tick_q <= frame_tick_d;
            map_pend_q   <= map_pend_d;
            hud_pend_q   <= hud_pend_d;
            draw_map_q   <= draw_map_d;
            draw_hud_q   <= draw_hud_d;
            erase_link_q <= erase_link_d;
            draw_link_q  <= draw_link_d;
            update_pos_q <= update_pos_d;
            busy_q       <= busy_d;
            dropped_q    <= dropped_d;
        end
    end

    assign draw_map       = draw_map_q;
    assign draw_HUD       = draw_hud_q;
    assign erase_link     = erase_link_q;
    assign draw_link      = draw_link_q;
    assign update_pos     = update_pos_q;
    assign frame_tick     = frame_tick_q;
    assign busy           = busy_q;
    assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer with FRAME_TICKS=10: reactive drawer
// models with randomized latencies and a frame-level expectation model.
module tb_draw_sequencer;
    localparam int unsigned FT = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       map_change;
    logic       hud_dirty;
    logic       draw_map_done;
    logic       draw_HUD_done;
    logic       draw_link_done;
    logic       draw_map;
    logic       draw_HUD;
    logic       erase_link;
    logic       draw_link;
    logic       update_pos;
    logic       frame_tick;
    logic       busy;
    logic [7:0] frames_dropped;

    draw_sequencer #(.FRAME_TICKS(FT)) dut (
        .clock          (clock),
        .reset          (reset),
        .map_change     (map_change),
        .hud_dirty      (hud_dirty),
        .draw_map_done  (draw_map_done),
        .draw_HUD_done  (draw_HUD_done),
        .draw_link_done (draw_link_done),
        .draw_map       (draw_map),
        .draw_HUD       (draw_HUD),
        .erase_link     (erase_link),
        .draw_link      (draw_link),
        .update_pos     (update_pos),
        .frame_tick     (frame_tick),
        .busy           (busy),
        .frames_dropped (frames_dropped)
    );

    always #5 clock = ~clock;

    // Cycle index: 0 is the cycle that begins with the last reset edge.
    int cyc = 0;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Drawer latencies (cycles a request is held before its done pulse).
    int lat_map = 1, lat_hud = 1, lat_erase = 1, lat_draw = 1;
    bit sprite_stall = 0;
    bit stray_hud    = 0;

    // Expectation state kept by the bench.
    bit hud_pend_m   = 0;
    int exp_dropped  = 0;

    // Drawer models: react just after each rising edge.
    initial begin : drawers
        int mc, hc, ec, dc;
        mc = 0; hc = 0; ec = 0; dc = 0;
        draw_map_done = 0; draw_HUD_done = 0; draw_link_done = 0;
        forever begin
            @(posedge clock);
            #1;
            mc = draw_map   ? mc + 1 : 0;
            hc = draw_HUD   ? hc + 1 : 0;
            ec = erase_link ? ec + 1 : 0;
            dc = draw_link  ? dc + 1 : 0;
            draw_map_done  = draw_map && (mc >= lat_map);
            draw_HUD_done  = (draw_HUD && (hc >= lat_hud)) || stray_hud;
            draw_link_done = !sprite_stall &&
                             ((erase_link && (ec >= lat_erase)) || (draw_link && (dc >= lat_draw)));
        end
    end

    function automatic logic [5:0] outs();
        return {draw_map, draw_HUD, erase_link, draw_link, update_pos, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        if (c > cyc) repeat (c - cyc) @(negedge clock);
    endtask

    // Positioned at cycle 0 after reset release: init map + HUD, then IDLE.
    task automatic check_init(input int lm, input int lh);
        logic [5:0] e;
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_dropped", 32'(frames_dropped), 32'd0);
        for (int c = 1; c <= lm + lh + 1; c++) begin
            goto(c);
            e = {c <= lm, (c > lm) && (c <= lm + lh), 1'b0, 1'b0, 1'b0, c <= lm + lh};
            chk("init_seq", 32'(outs()), 32'(e));
        end
    endtask

    // One frame started by the tick at cycle t; dmask bit i pulses hud_dirty
    // in cycle t+1+i.
    task automatic run_frame(input int t, input int le, input int ld, input int lh,
                             input logic [15:0] dmask, input string tag);
        bit hud_now, pend_next;
        int len;
        logic [5:0] e;
        hud_now = hud_pend_m;
        pend_next = 0;
        for (int i = 0; i < 16; i++) begin
            if (dmask[i]) begin
                if (i < le + ld) hud_now = 1;
                else             pend_next = 1;
            end
        end
        len = le + 1 + ld + (hud_now ? lh : 0);
        lat_erase = le; lat_draw = ld; lat_hud = lh;
        goto(t);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd1);
        chk({tag, "_idle"}, 32'(outs()), 32'd0);
        for (int i = 0; i <= len; i++) begin
            goto(t + 1 + i);
            e = {1'b0, (i > le + ld) && (i < len), i < le, (i > le) && (i <= le + ld),
                 i == le, i < len};
            chk(tag, 32'(outs()), 32'(e));
            chk({tag, "_dropped"}, 32'(frames_dropped), 32'(exp_dropped));
            hud_dirty = (i < 16) ? dmask[i] : 1'b0;
        end
        @(negedge clock);
        hud_dirty = 0;
        hud_pend_m = pend_next;
    endtask

    // map_change lands so its pending flag meets the tick at cycle t in IDLE.
    task automatic check_map(input int t, input int lm, input int lh);
        logic [5:0] e;
        lat_map = lm; lat_hud = lh;
        goto(t - 1);
        map_change = 1;
        goto(t);
        map_change = 0;
        chk("map_tick", 32'(frame_tick), 32'd1);
        for (int i = 0; i <= lm + lh; i++) begin
            goto(t + 1 + i);
            e = {i < lm, (i >= lm) && (i < lm + lh), 1'b0, 1'b0, 1'b0, i < lm + lh};
            chk("map_seq", 32'(outs()), 32'(e));
            chk("map_dropped", 32'(frames_dropped), 32'(exp_dropped));
        end
        hud_pend_m = 0;
    endtask

    // Sprite drawer stalls in ERASE for n frame ticks, then acks.
    task automatic stall_frame(input int t, input int n);
        int base, ticks, expd;
        base = exp_dropped;
        lat_erase = 1; lat_draw = 1;
        sprite_stall = 1;
        goto(t);
        chk("stall_tick", 32'(frame_tick), 32'd1);
        for (int c = t + 1; c <= t + 10 * n + 1; c++) begin
            goto(c);
            ticks = (c - 1 - t) / 10;
            expd = (base + ticks > 255) ? 255 : base + ticks;
            chk("stall_erase", 32'(outs()), 32'(6'b001001));
            chk("stall_dropped", 32'(frames_dropped), 32'(expd));
            if (c == t + 10 * n) sprite_stall = 0;
        end
        exp_dropped = (base + n > 255) ? 255 : base + n;
        goto(t + 10 * n + 2);
        chk("stall_update", 32'(outs()), 32'(6'b000011));
        goto(t + 10 * n + 3);
        chk("stall_draw", 32'(outs()), 32'(6'b000101));
        goto(t + 10 * n + 4);
        chk("stall_idle", 32'(outs()), 32'd0);
        chk("stall_final_dropped", 32'(frames_dropped), 32'(exp_dropped));
    endtask

    initial begin : main
        logic [15:0] m;
        int le, ld, lh, p;
        reset = 1; map_change = 0; hud_dirty = 0;
        repeat (3) @(negedge clock);
        reset = 0;

        // Power-on: map acked after 3 cycles, HUD after 3.
        lat_map = 3; lat_hud = 3;
        check_init(3, 3);

        // Plain frame, sprite acks after 2 cycles, no HUD.
        run_frame(10, 2, 2, 1, 16'h0000, "frame_plain");

        // hud_dirty in ERASE and again on the HUD-entry edge.
        le = $urandom_range(1, 2); ld = $urandom_range(1, 2); lh = $urandom_range(1, 2);
        m = '0; m[0] = 1'b1; m[le + ld] = 1'b1;
        run_frame(20, le, ld, lh, m, "frame_dirty");
        run_frame(30, $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2),
                  16'h0000, "frame_redraw");
        run_frame(40, 1, 1, 1, 16'h0000, "frame_clean");

        for (int k = 0; k < 8; k++) begin
            le = $urandom_range(1, 2); ld = $urandom_range(1, 2); lh = $urandom_range(1, 2);
            m = '0;
            if ($urandom_range(0, 2) != 0) begin
                p = $urandom_range(0, le + ld + 1); m[p] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, le + ld + 1); m[p] = 1'b1;
            end
            run_frame(50 + 10 * k, le, ld, lh, m, "frame_rand");
        end

        // Map change beats the coincident tick; the next tick runs a frame.
        check_map(130, $urandom_range(1, 2), $urandom_range(1, 2));
        run_frame(140, 1, 2, 1, 16'h0000, "frame_after_map");

        // Overruns: three lost frames, then saturation.
        stall_frame(150, 3);
        run_frame(190, 2, 1, 1, 16'h0000, "frame_after_stall");
        stall_frame(200, 300);
        run_frame(3210, 1, 1, 1, 16'h0000, "frame_saturated");

        // Reset in DRAW with both pending flags set.
        lat_erase = 2; lat_draw = 3;
        goto(3221);
        map_change = 1; hud_dirty = 1;
        goto(3222);
        map_change = 0; hud_dirty = 0;
        goto(3224);
        chk("pre_reset_draw", 32'(outs()), 32'(6'b000101));
        reset = 1;
        @(negedge clock);
        reset = 0;
        exp_dropped = 0; hud_pend_m = 0;
        lat_map = 1; lat_hud = 1;
        check_init(1, 1);

        // Stray HUD done in IDLE changes nothing.
        goto(4);
        stray_hud = 1;
        goto(5);
        stray_hud = 0;
        for (int c = 6; c <= 9; c++) begin
            goto(c);
            chk("stray_idle", 32'(outs()), 32'd0);
        end
        run_frame(10, 1, 1, 1, 16'h0000, "frame_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
